debug_regdump_tx: RTL and testbench

- Debug-path consumer of the register bank's five debug read ports (registers 0..4).
- On a start request, snapshots all debug words in one cycle.
- Streams the snapshot as a byte frame over a valid/ready handshake to the debug UART transmitter.
- Sits between the register bank and the UART TX in the pipe-and-debug datapath.

---
 rtl/debug_regdump_tx_pkg.sv | 30 +++
 rtl/debug_regdump_tx_if.sv | 13 +
 rtl/debug_regdump_tx_byte_shifter.sv | 43 ++++
 rtl/debug_regdump_tx.sv | 111 +++++++++++
 tb/tb_debug_regdump_tx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_regdump_tx_pkg.sv
// debug_pkg: shared definitions for the debug register-dump transmitter.
//   - dumpState_t : FSM state encoding (IDLE/SEND/CSUM/DONE)
//   - BYTE_W      : byte width of the transmit stream
//   - calcNBytes  : frame length in data bytes for a given word width/count
//   - calcCntW    : byte-counter width able to hold 0..NBYTES
package debug_pkg;

  localparam int BYTE_W = 8;

  // CSUM is only reachable when the checksum byte is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } dumpState_t;

  function automatic int calcNBytes(input int wordWide, input int numWords);
    return (wordWide * numWords) / BYTE_W;
  endfunction

  // One extra count so the counter can reach NBYTES without wrapping.
  function automatic int calcCntW(input int nBytes);
    return $clog2(nBytes + 1);
  endfunction

  localparam int NBYTES_DEFAULT = calcNBytes(32, 5);
  localparam int CNT_W_DEFAULT  = calcCntW(NBYTES_DEFAULT);

endpackage

// File: rtl/debug_regdump_tx_if.sv
// debug_regdump_tx_if: byte stream towards the debug UART transmitter.
//   txData  - byte presented to the UART
//   txValid - txData is valid
//   txReady - UART accepts the byte this cycle
// master = dump block (drives data/valid), slave = UART TX.
interface debug_regdump_tx_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;

  modport master (output txData, output txValid, input txReady);
  modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/debug_regdump_tx_byte_shifter.sv
// debug_byte_shifter: shadow copy of the debug bus that serialises it MSB
// byte first.
//   clock, reset - system clock, synchronous active-high reset
//   load         - capture loadData (word 0 ends up in the top bits)
//   shift        - drop the top byte, shifting left by one byte
//   loadData     - flat debug bus, word i at [i*word_wide +: word_wide]
//   topByte      - current byte to transmit
module debug_byte_shifter
  import debug_pkg::*;
#(
  parameter int word_wide = 32,
  parameter int num_words = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           shift,
  input  logic [num_words*word_wide-1:0] loadData,
  output logic [BYTE_W-1:0]              topByte
);

  localparam int TOTAL_W = num_words * word_wide;

  logic [TOTAL_W-1:0] shadow;
  logic [TOTAL_W-1:0] ordered;

  // Reverse word order so word 0 sits at the top and leaves first; bytes
  // within a word are already MSB-first in this layout.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < num_words; i++)
      ordered[(num_words-1-i)*word_wide +: word_wide] = loadData[i*word_wide +: word_wide];
  end

  always_ff @(posedge clock) begin
    if (reset)      shadow <= '0;
    else if (load)  shadow <= ordered;
    else if (shift) shadow <= shadow << BYTE_W;
  end

  assign topByte = shadow[TOTAL_W-1 -: BYTE_W];

endmodule

// File: rtl/debug_regdump_tx.sv
// debug_regdump_tx: snapshots the register bank's debug read ports on a
// start request and streams them as a byte frame to the debug UART.
//   clock, reset - system clock, synchronous active-high reset
//   start        - dump request, honoured only in IDLE
//   dbgRegs      - flat debug bus, word i at [i*word_wide +: word_wide]
//   tx           - byte stream (txData/txValid/txReady), master side
//   busy         - frame in progress
//   done         - one-cycle pulse after the last byte is accepted
// Build option: DEBUG_DUMP_CHECKSUM_EN appends a mod-256 sum of the data
// bytes as a final byte.
module debug_regdump_tx
  import debug_pkg::*;
#(
  parameter int word_wide = 32,
  parameter int num_words = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [num_words*word_wide-1:0] dbgRegs,
  debug_regdump_tx_if.master             tx,
  output logic                           busy,
  output logic                           done
);

  localparam int NBYTES = calcNBytes(word_wide, num_words);
  localparam int CNT_W  = calcCntW(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  dumpState_t        state, nextState;
  logic [CNT_W-1:0]  byteCnt;
  logic [BYTE_W-1:0] shByte;
  logic              capture;
  logic              sendXfer;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] csumAcc;
`endif

  assign sendXfer = (state == SEND) && tx.txReady;
  assign busy     = (state != IDLE);

  debug_byte_shifter #(
    .word_wide (word_wide),
    .num_words (num_words)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (capture),
    .shift    (sendXfer),
    .loadData (dbgRegs),
    .topByte  (shByte)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    capture    = 1'b0;
    done       = 1'b0;
    tx.txValid = 1'b0;
    tx.txData  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          nextState = SEND;
        end
      end
      SEND: begin
        tx.txValid = 1'b1;
        tx.txData  = shByte;
        if (tx.txReady && (byteCnt == LAST_IDX))
`ifdef DEBUG_DUMP_CHECKSUM_EN
          nextState = CSUM;
`else
          nextState = DONE;
`endif
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      CSUM: begin
        tx.txValid = 1'b1;
        tx.txData  = csumAcc;
        if (tx.txReady) nextState = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || capture) byteCnt <= '0;
    else if (sendXfer)    byteCnt <= byteCnt + 1'b1;
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Running sum of bytes as they are accepted; ready by the time CSUM is entered.
  always_ff @(posedge clock) begin
    if (reset || capture) csumAcc <= '0;
    else if (sendXfer)    csumAcc <= csumAcc + shByte;
  end
`endif

endmodule

// File: tb/tb_debug_regdump_tx.sv
module tb_debug_regdump_tx;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [159:0] dbgRegs;
  logic         busy, done;

  debug_regdump_tx_if txIf();

  debug_regdump_tx #(.word_wide(32), .num_words(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .dbgRegs (dbgRegs),
    .tx      (txIf),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [7:0]  sb[$];
  logic [31:0] regs[5];
  int xferCount = 0;
  int doneCount = 0;
  bit readyMode = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void driveBus();
    for (int i = 0; i < 5; i++) dbgRegs[i*32 +: 32] = regs[i];
  endfunction

  // Expected frame: word 0 first, MSB first, optional mod-256 sum.
  function automatic void pushFrame();
    logic [7:0] sum;
    logic [31:0] w;
    sum = 8'h00;
    for (int i = 0; i < 5; i++) begin
      w = regs[i];
      for (int b = 3; b >= 0; b--) begin
        sb.push_back(w[b*8 +: 8]);
        sum = sum + w[b*8 +: 8];
      end
    end
    if (CS_EN) sb.push_back(sum);
  endfunction

  // Ready generator: always ready, or ready one cycle in three.
  initial begin
    int phase;
    phase = 0;
    txIf.txReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (readyMode) begin
        phase = (phase + 1) % 3;
        txIf.txReady = (phase == 0);
      end else begin
        txIf.txReady = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte.
  initial begin
    bit prevStall, prevDone;
    logic [7:0] prevData;
    logic [7:0] exp;
    prevStall = 1'b0;
    prevDone  = 1'b0;
    prevData  = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall = 1'b0;
        prevDone  = 1'b0;
      end else begin
        if (txIf.txValid && prevStall) check("stall_hold", txIf.txData, prevData);
        if (txIf.txValid && txIf.txReady) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %0h expected none", txIf.txData);
          end else begin
            exp = sb.pop_front();
            check("byte", txIf.txData, exp);
          end
          xferCount++;
        end
        if (done) begin
          doneCount++;
          check("busy_in_done", busy, 1);
          check("valid_in_done", txIf.txValid, 0);
        end
        if (prevDone) check("busy_after_done", busy, 0);
        prevStall = txIf.txValid && !txIf.txReady;
        prevData  = txIf.txData;
        prevDone  = done;
      end
    end
  end

  task automatic waitDone(input int target, input int budget);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check("done_reached", (doneCount >= target), 1);
  endtask

  task automatic waitXfer(input int target, input int budget);
    int n;
    n = 0;
    while (xferCount < target && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check("xfer_reached", (xferCount >= target), 1);
  endtask

  task automatic pulseStart();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic settleCheck(input string name, input int expDone);
    repeat (3) @(negedge clock);
    #1;
    check({name, "_done_cnt"}, doneCount, expDone);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    logic doneArr[50];
    logic busyArr[50];
    int d, base, k;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) regs[i] = 32'd90 + i;
    driveBus();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", txIf.txValid, 0);
    check("rst_data", txIf.txData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Basic frame, ready tied high, with first-byte latency check.
    d = doneCount;
    pushFrame();
    @(posedge clock); #1 start = 1'b1;
    @(negedge clock);
    check("pre_capture_valid", txIf.txValid, 0);
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("first_latency", txIf.txValid, 1);
    check("first_byte", txIf.txData, 8'h00);
    check("busy_sending", busy, 1);
    waitDone(d + 1, 200);
    settleCheck("basic", d + 1);

    // Backpressure: ready one cycle in three.
    d = doneCount;
    readyMode = 1'b1;
    pushFrame();
    pulseStart();
    waitDone(d + 1, 400);
    readyMode = 1'b0;
    settleCheck("bp", d + 1);

    // Snapshot isolation: word 0 changes right after capture.
    d = doneCount;
    pushFrame();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    dbgRegs[31:0] = 32'hDEADBEEF;
    waitDone(d + 1, 200);
    settleCheck("snap", d + 1);
    driveBus();

    // Start pulse mid-frame is ignored.
    d = doneCount;
    base = xferCount;
    pushFrame();
    pulseStart();
    waitXfer(base + 7, 100);
    pulseStart();
    waitDone(d + 1, 200);
    settleCheck("busy_start", d + 1);

    // Reset mid-frame, then a clean frame.
    d = doneCount;
    base = xferCount;
    pushFrame();
    pulseStart();
    waitXfer(base + 10, 100);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_valid", txIf.txValid, 0);
    check("rst_mid_busy", busy, 0);
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    check("rst_mid_no_done", doneCount, d);
    pushFrame();
    pulseStart();
    waitDone(d + 1, 200);
    settleCheck("after_rst", d + 1);

    // Start held for 50 edges: three back-to-back frames.
    d = doneCount;
    for (int f = 0; f < 3; f++) pushFrame();
    @(posedge clock); #1 start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      doneArr[c] = done;
      busyArr[c] = busy;
    end
    @(posedge clock); #1 start = 1'b0;
    k = -1;
    for (int c = 0; c < 48; c++)
      if (k < 0 && doneArr[c]) k = c;
    check("held_done_seen", (k >= 0), 1);
    if (k >= 0) begin
      check("held_idle_gap", busyArr[k+1], 0);
      check("held_restart", busyArr[k+2], 1);
    end
    waitDone(d + 3, 300);
    settleCheck("held", d + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
